// File: rtl/seg7_pkg.sv
// Shared types and constants for the 7-segment scan multiplexer.
package seg7_pkg;

  localparam int unsigned BcdW = 4;
  localparam logic [BcdW-1:0] BcdMax = 4'd9;

  typedef enum logic [1:0] {StOff, StGuard, StShow} state_e;

  // Digit index width; a single-digit display still gets one index bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/seg7_scan_mux_if.sv
// Digit load inputs and scanned display outputs of the 7-segment scan multiplexer.
interface seg7_scan_mux_if
  import seg7_pkg::*;
#(
  parameter int unsigned NumDigits = 4
);

  localparam int unsigned IdxW = idx_width(NumDigits);

  logic                      en;
  logic                      load;
  logic [BcdW*NumDigits-1:0] digits_bcd;
  logic [NumDigits-1:0]      dp_in;
  logic [BcdW-1:0]           bcd_out;
  logic                      blank_out;
  logic                      dp_out;
  logic [NumDigits-1:0]      an;
  logic [IdxW-1:0]           digit_idx;
  logic                      frame_tick;

  modport master (
    output en, load, digits_bcd, dp_in,
    input  bcd_out, blank_out, dp_out, an, digit_idx, frame_tick
  );

  modport slave (
    input  en, load, digits_bcd, dp_in,
    output bcd_out, blank_out, dp_out, an, digit_idx, frame_tick
  );

endinterface

// File: rtl/seg7_blank_logic.sv
// Per-digit blank vector: invalid (>9) codes and, optionally, leading zeros.
module seg7_blank_logic
  import seg7_pkg::*;
#(
  parameter int unsigned NumDigits    = 4,
  parameter bit          BlankLeading = 1'b1
) (
  input  logic [BcdW*NumDigits-1:0] digits_i,
  output logic [NumDigits-1:0]      blank_o
);

  logic            zero_run;
  logic [BcdW-1:0] dig;

  // Walk from the most significant digit down; zero_run stays set while all digits so far are 0.
  always_comb begin
    blank_o  = '0;
    zero_run = 1'b1;
    dig      = '0;
    for (int k = NumDigits - 1; k >= 0; k--) begin
      dig        = digits_i[k*BcdW +: BcdW];
      zero_run   = zero_run && (dig == '0);
      blank_o[k] = (dig > BcdMax) || (BlankLeading && zero_run && (k != 0));
    end
  end

endmodule

// File: rtl/seg7_scan_mux.sv
// Time-multiplexed common-anode 7-segment scanner with guard gap and tear-free frame updates.
module seg7_scan_mux
  import seg7_pkg::*;
#(
  parameter int unsigned NumDigits    = 4,
  parameter int unsigned RefreshDiv   = 100000,
  parameter int unsigned GuardCycles  = 2,
  parameter bit          BlankLeading = 1'b1
) (
  input logic             clk,
  input logic             rst,
  seg7_scan_mux_if.slave  bus
);

  localparam int unsigned     IdxW      = idx_width(NumDigits);
  localparam int unsigned     DigW      = BcdW * NumDigits;
  localparam logic [IdxW-1:0] LastIdx   = IdxW'(NumDigits - 1);
  localparam logic [31:0]     GuardLast = 32'(GuardCycles - 1);
  localparam logic [31:0]     ShowLast  = 32'(RefreshDiv - 1);

  state_e               state_q, state_d;
  logic [31:0]          cnt_q, cnt_d;
  logic [IdxW-1:0]      idx_q, idx_d;
  logic [DigW-1:0]      pend_dig_q, pend_dig_d;
  logic [NumDigits-1:0] pend_dp_q, pend_dp_d;
  logic [DigW-1:0]      disp_dig_q, disp_dig_d;
  logic [NumDigits-1:0] disp_dp_q, disp_dp_d;
  logic [NumDigits-1:0] an_q, an_d;
  logic [BcdW-1:0]      bcd_q, bcd_d;
  logic                 blank_q, blank_d;
  logic                 dp_q, dp_d;
  logic                 tick_q, tick_d;
  logic                 load_disp;
  logic [NumDigits-1:0] blank_vec;

  seg7_blank_logic #(
    .NumDigits    (NumDigits),
    .BlankLeading (BlankLeading)
  ) u_blank (
    .digits_i (disp_dig_d),
    .blank_o  (blank_vec)
  );

  // Next-state: scan sequencing and pending/display register updates.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    pend_dig_d = pend_dig_q;
    pend_dp_d  = pend_dp_q;
    disp_dig_d = disp_dig_q;
    disp_dp_d  = disp_dp_q;
    tick_d     = 1'b0;
    load_disp  = 1'b0;

    if (bus.load) begin
      pend_dig_d = bus.digits_bcd;
      pend_dp_d  = bus.dp_in;
    end

    if (!bus.en) begin
      state_d = StOff;
      cnt_d   = '0;
      idx_d   = '0;
    end else begin
      unique case (state_q)
        StOff: begin
          state_d   = StGuard;
          cnt_d     = '0;
          idx_d     = '0;
          load_disp = 1'b1;
        end
        StGuard: begin
          if (cnt_q == GuardLast) begin
            state_d = StShow;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 32'd1;
          end
        end
        StShow: begin
          if (cnt_q == ShowLast) begin
            state_d = StGuard;
            cnt_d   = '0;
            if (idx_q == LastIdx) begin
              idx_d     = '0;
              load_disp = 1'b1;
              tick_d    = 1'b1;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 32'd1;
          end
        end
        default: begin
          state_d = StOff;
          cnt_d   = '0;
          idx_d   = '0;
        end
      endcase
    end

    // A load landing on the update edge bypasses pending so it is not lost for a frame.
    if (load_disp) begin
      disp_dig_d = bus.load ? bus.digits_bcd : pend_dig_q;
      disp_dp_d  = bus.load ? bus.dp_in      : pend_dp_q;
    end
  end

  // Outputs are derived from next state so every output register moves on the same edge.
  always_comb begin
    an_d    = '1;
    bcd_d   = '0;
    dp_d    = 1'b0;
    blank_d = 1'b1;
    if (state_d == StShow) begin
      an_d[idx_d] = 1'b0;
      bcd_d       = disp_dig_d[32'(idx_d) * BcdW +: BcdW];
      dp_d        = disp_dp_d[idx_d];
      blank_d     = blank_vec[idx_d];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StOff;
      cnt_q      <= '0;
      idx_q      <= '0;
      pend_dig_q <= '0;
      pend_dp_q  <= '0;
      disp_dig_q <= '0;
      disp_dp_q  <= '0;
      an_q       <= '1;
      bcd_q      <= '0;
      blank_q    <= 1'b1;
      dp_q       <= 1'b0;
      tick_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      pend_dig_q <= pend_dig_d;
      pend_dp_q  <= pend_dp_d;
      disp_dig_q <= disp_dig_d;
      disp_dp_q  <= disp_dp_d;
      an_q       <= an_d;
      bcd_q      <= bcd_d;
      blank_q    <= blank_d;
      dp_q       <= dp_d;
      tick_q     <= tick_d;
    end
  end

  assign bus.an         = an_q;
  assign bus.bcd_out    = bcd_q;
  assign bus.blank_out  = blank_q;
  assign bus.dp_out     = dp_q;
  assign bus.digit_idx  = idx_q;
  assign bus.frame_tick = tick_q;

endmodule
